fifo_drain_arbiter: RTL and testbench
=====================================

// Module: fifo_drain_arbiter
// PURPOSE
//  Slow-domain read-side controller for the two async FIFOs of dual_domain_transfer.
//  Drains both FIFOs with burst-limited round-robin into one tagged output stream
//  using a valid/ready handshake. Issues the FIFO rd_en strobes, so a FIFO is never read while empty.
//  Buffers data through a 2-entry output skid buffer, so it sustains 1 word/cycle with no loss under backpressure.
// PARAMETERS
//  WIDTH  8   data width of each FIFO and of m_data
//  BURST  4   max consecutive reads granted to one source before re-arbitration (1..255)
// PORTS
//  clk_slow  in   1      read-side (slow) clock; the only clock
//  rst_n     in   1      asynchronous, active-low reset
//  en1       in   1      source 1 enable; 0 = never grant FIFO 1
//  en2       in   1      source 2 enable; 0 = never grant FIFO 2
//  empty1    in   1      FIFO 1 empty (already reflects rd_en1 of the previous cycle)
//  empty2    in   1      FIFO 2 empty
//  dout1     in   WIDTH  FIFO 1 read data, valid the cycle after rd_en1
//  dout2     in   WIDTH  FIFO 2 read data, valid the cycle after rd_en2
//  rd_en1    out  1      FIFO 1 read strobe
//  rd_en2    out  1      FIFO 2 read strobe
//  m_data    out  WIDTH  merged output data (head of the skid buffer)
//  m_src     out  1      source tag of m_data: 0 = FIFO 1, 1 = FIFO 2
//  m_valid   out  1      m_data/m_src valid
//  m_ready   in   1      downstream accept; a beat transfers when m_valid & m_ready
//  cnt1      out  16     words delivered from source 1 (wraps at 2^16)
//  cnt2      out  16     words delivered from source 2 (wraps at 2^16)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, last_grant=2, skid empty, in-flight flag clear.
//  FSM states:
//   - IDLE: pick an enabled source whose FIFO is non-empty.
//     If both qualify, pick the one != last_grant.
//     Go to G1 or G2, beat count = 0. Nothing is read in IDLE.
//   - G1/G2 (source x):
//     rd_enx = !emptyx & enx & slot_ok; each read does beat++.
//     slot_ok = (occ + inflight - pop) < 2, where:
//       occ = skid entries (0..2), inflight = read issued last cycle, pop = m_valid & m_ready.
//   - Leave Gx when beat reaches BURST, or when emptyx / !enx is seen:
//     - other source qualifies -> G(other), beat = 0, last_grant = x.
//     - else only x qualifies (burst end) -> stay in Gx, beat = 0.
//     - else -> IDLE.
//     Reads continue in the switch cycle only on the new grant, from the next cycle.
//  rd_en1 and rd_en2 are never high in the same cycle.
//  A FIFO is never read while its empty flag or its enable is low-qualified.
//  Latency: rd_en in cycle t; dout captured at end of t+1; earliest m_valid in cycle t+2.
//  Skid buffer: 2 entries, FIFO order; push and pop in the same cycle are allowed.
//  slot_ok guarantees there is never an overflow; m_data/m_src stay stable while m_valid & !m_ready.
//  cntx increments on each transfer with m_src = x-1; both counters may wrap independently.
//  en deasserted mid-burst: no new reads for that source; in-flight and buffered words still deliver.
//  rst_n low mid-operation: in-flight and buffered words are dropped; FSM returns to IDLE.
// TESTING
//  1. Reset: rst_n=0 with non-empty FIFOs -> rd_en1/2, m_valid, cnt1/2 all 0; none toggle until release.
//  2. FIFO1 holds A1,A2,A3, FIFO2 empty, m_ready=1 -> rd_en1 high 3 consecutive cycles;
//     m_data A1,A2,A3 with m_src=0 from 2 cycles after the first rd_en1; cnt1=3.
//  3. Both FIFOs hold 8 words, BURST=4, m_ready=1 ->
//     reads 1,1,1,1,2,2,2,2,1,1,1,1,2,2,2,2 (one switch cycle allowed at each boundary); cnt1=cnt2=8.
//  4. m_ready=0, FIFO1 full -> exactly 2 rd_en1 pulses then rd_en1 stays 0 and m_data holds;
//     m_ready=1 -> remaining words in order, no duplicates or drops.
//  5. en2=0, both FIFOs non-empty -> rd_en2 never asserts; FIFO1 fully drained; set en2=1 -> FIFO2 drained.
//  6. rst_n pulsed low mid-burst (2 words in skid) -> m_valid 0 next cycle;
//     after release, arbitration restarts with source 1 (last_grant=2).

Source files
------------

// File: rtl/fifo_drain_arbiter_if.sv
// +----------------------------------------------------------------------+
// | fifo_drain_arbiter_if - FIFO read side and merged output stream. Rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

interface fifo_drain_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             en1;
  logic             en2;
  logic             empty1;
  logic             empty2;
  logic [WIDTH-1:0] dout1;
  logic [WIDTH-1:0] dout2;
  logic             rd_en1;
  logic             rd_en2;
  logic [WIDTH-1:0] m_data;
  logic             m_src;
  logic             m_valid;
  logic             m_ready;
  logic [15:0]      cnt1;
  logic [15:0]      cnt2;

  modport master (
    input  en1, en2, empty1, empty2, dout1, dout2, m_ready,
    output rd_en1, rd_en2, m_data, m_src, m_valid, cnt1, cnt2
  );

  modport slave (
    output en1, en2, empty1, empty2, dout1, dout2, m_ready,
    input  rd_en1, rd_en2, m_data, m_src, m_valid, cnt1, cnt2
  );
endinterface

`default_nettype wire

// File: rtl/fifo_drain_arbiter.sv
// +----------------------------------------------------------------------+
// | fifo_drain_arbiter - burst round-robin drain of two FIFOs. Rev 1.0     |
// +----------------------------------------------------------------------+
`default_nettype none

module fifo_drain_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4
) (
  input  logic                  clk_slow,
  input  logic                  rst_n,
  fifo_drain_arbiter_if.master  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_G1    = 2'd1;
  localparam logic [1:0] S_G2    = 2'd2;
  localparam logic [7:0] BURST_C = 8'(BURST);

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [7:0]       beat_q, beat_d;
  logic             inflight_q, inflight_d;
  logic             inflight_src_q, inflight_src_d;
  logic [1:0]       occ_q, occ_d;
  logic [WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic             src0_q, src0_d, src1_q, src1_d;
  logic [15:0]      cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  logic             qual1, qual2;
  logic             rd1, rd2;
  logic             pop, push, slot_ok;
  logic [1:0]       pending;
  logic [WIDTH-1:0] push_data;

  assign qual1   = bus.en1 & ~bus.empty1;
  assign qual2   = bus.en2 & ~bus.empty2;
  assign pop     = (occ_q != 2'd0) & bus.m_ready;
  assign push    = inflight_q;
  // Entries that will be held once every issued read has landed.
  assign pending = occ_q + {1'b0, inflight_q} - {1'b0, pop};
  assign slot_ok = (pending < 2'd2);
  assign push_data = inflight_src_q ? bus.dout2 : bus.dout1;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    rd1     = 1'b0;
    rd2     = 1'b0;
    case (state_q)
      S_IDLE: begin
        // last_q = 1 means source 2 was granted last, so source 1 wins a tie.
        if (qual1 && (!qual2 || last_q)) begin
          state_d = S_G1;
          beat_d  = 8'd0;
        end else if (qual2) begin
          state_d = S_G2;
          beat_d  = 8'd0;
        end
      end
      S_G1: begin
        if ((beat_q == BURST_C) || !qual1) begin
          beat_d = 8'd0;
          if (qual2) begin
            state_d = S_G2;
            last_d  = 1'b0;
          end else if (!qual1) begin
            state_d = S_IDLE;
          end
        end else if (slot_ok) begin
          rd1    = 1'b1;
          beat_d = beat_q + 8'd1;
        end
      end
      S_G2: begin
        if ((beat_q == BURST_C) || !qual2) begin
          beat_d = 8'd0;
          if (qual1) begin
            state_d = S_G1;
            last_d  = 1'b1;
          end else if (!qual2) begin
            state_d = S_IDLE;
          end
        end else if (slot_ok) begin
          rd2    = 1'b1;
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data0_d        = data0_q;
    data1_d        = data1_q;
    src0_d         = src0_q;
    src1_d         = src1_q;
    occ_d          = occ_q;
    inflight_d     = rd1 | rd2;
    inflight_src_d = rd2;
    cnt1_d         = cnt1_q + {15'd0, pop & ~src0_q};
    cnt2_d         = cnt2_q + {15'd0, pop & src0_q};
    case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = push_data;
          src0_d  = inflight_src_q;
        end else begin
          data1_d = push_data;
          src1_d  = inflight_src_q;
        end
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        data0_d = data1_q;
        src0_d  = src1_q;
        occ_d   = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = push_data;
          src0_d  = inflight_src_q;
        end else begin
          data0_d = data1_q;
          src0_d  = src1_q;
          data1_d = push_data;
          src1_d  = inflight_src_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      last_q         <= 1'b1;
      beat_q         <= 8'd0;
      inflight_q     <= 1'b0;
      inflight_src_q <= 1'b0;
      occ_q          <= 2'd0;
      data0_q        <= '0;
      data1_q        <= '0;
      src0_q         <= 1'b0;
      src1_q         <= 1'b0;
      cnt1_q         <= 16'd0;
      cnt2_q         <= 16'd0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      beat_q         <= beat_d;
      inflight_q     <= inflight_d;
      inflight_src_q <= inflight_src_d;
      occ_q          <= occ_d;
      data0_q        <= data0_d;
      data1_q        <= data1_d;
      src0_q         <= src0_d;
      src1_q         <= src1_d;
      cnt1_q         <= cnt1_d;
      cnt2_q         <= cnt2_d;
    end
  end

  assign bus.rd_en1  = rd1;
  assign bus.rd_en2  = rd2;
  assign bus.m_data  = data0_q;
  assign bus.m_src   = src0_q;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.cnt1    = cnt1_q;
  assign bus.cnt2    = cnt2_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_drain_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_fifo_drain_arbiter - bench for fifo_drain_arbiter. Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_fifo_drain_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  int   cyc;

  fifo_drain_arbiter_if #(.WIDTH(8)) bus ();

  fifo_drain_arbiter #(.WIDTH(8), .BURST(4)) dut (
    .clk_slow (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  logic [7:0]  fq1[$], fq2[$];
  logic [7:0]  exp1[$], exp2[$];
  bit          rdsrc[$];
  int          rdcyc[$];
  int          xcyc[$];
  logic [15:0] mcnt1, mcnt2;
  bit          stall;
  logic [9:0]  held;
  int          r1, r2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO models: empty reflects the read taken at this edge, dout arrives a cycle later.
  always @(posedge clk) begin
    logic [7:0] w;
    cyc <= cyc + 1;
    if (bus.rd_en1 && fq1.size() != 0) begin
      w = fq1.pop_front();
      bus.dout1 <= w;
      exp1.push_back(w);
    end
    if (bus.rd_en2 && fq2.size() != 0) begin
      w = fq2.pop_front();
      bus.dout2 <= w;
      exp2.push_back(w);
    end
    bus.empty1 <= (fq1.size() == 0);
    bus.empty2 <= (fq2.size() == 0);
  end

  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      chk("rst_rd_en1", 32'(bus.rd_en1), 0);
      chk("rst_rd_en2", 32'(bus.rd_en2), 0);
      chk("rst_m_valid", 32'(bus.m_valid), 0);
      chk("rst_m_data", 32'(bus.m_data), 0);
      chk("rst_cnt1", 32'(bus.cnt1), 0);
      chk("rst_cnt2", 32'(bus.cnt2), 0);
      exp1.delete();
      exp2.delete();
      mcnt1 = 16'd0;
      mcnt2 = 16'd0;
      stall = 1'b0;
    end else begin
      if (bus.rd_en1 || bus.rd_en2) begin
        chk("rd_onehot", 32'(bus.rd_en1 & bus.rd_en2), 0);
        if (bus.rd_en1) chk("rd1_legal", 32'(bus.en1 & ~bus.empty1), 1);
        if (bus.rd_en2) chk("rd2_legal", 32'(bus.en2 & ~bus.empty2), 1);
        rdsrc.push_back(bus.rd_en2);
        rdcyc.push_back(cyc);
      end
      if (stall) chk("hold", 32'({bus.m_valid, bus.m_src, bus.m_data}), 32'(held));
      chk("cnt1", 32'(bus.cnt1), 32'(mcnt1));
      chk("cnt2", 32'(bus.cnt2), 32'(mcnt2));
      if (bus.m_valid && bus.m_ready) begin
        xcyc.push_back(cyc);
        if (!bus.m_src) begin
          chk("xfer1_expected", 32'(exp1.size() != 0), 1);
          if (exp1.size() != 0) begin
            e = exp1.pop_front();
            chk("data1", 32'(bus.m_data), 32'(e));
          end
          mcnt1 = mcnt1 + 16'd1;
        end else begin
          chk("xfer2_expected", 32'(exp2.size() != 0), 1);
          if (exp2.size() != 0) begin
            e = exp2.pop_front();
            chk("data2", 32'(bus.m_data), 32'(e));
          end
          mcnt2 = mcnt2 + 16'd1;
        end
      end
      stall = bus.m_valid & ~bus.m_ready;
      held  = {bus.m_valid, bus.m_src, bus.m_data};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    rdsrc.delete();
    rdcyc.delete();
    xcyc.delete();
  endtask

  task automatic drain(input bit need2, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      step(1);
      done = (fq1.size() == 0) && (exp1.size() == 0) && !bus.m_valid &&
             (!need2 || ((fq2.size() == 0) && (exp2.size() == 0)));
    end
    chk("drain_done", 32'(done), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones;
    n_cmp = 0; n_fail = 0; cyc = 0; r1 = 0; r2 = 0;
    mcnt1 = 16'd0; mcnt2 = 16'd0; stall = 1'b0; held = '0;
    rst_n = 1'b0;
    bus.en1 = 1'b1; bus.en2 = 1'b1; bus.m_ready = 1'b1;

    // Reset held with FIFO 1 non-empty, then a 3-word drain.
    for (int i = 0; i < 3; i++) fq1.push_back(8'hA1 + 8'(i));
    step(5);
    clear_logs();
    rst_n = 1'b1;
    step(10);
    chk("t2_reads", 32'(rdsrc.size()), 3);
    if (rdsrc.size() >= 3) begin
      chk("t2_src", 32'({rdsrc[0], rdsrc[1], rdsrc[2]}), 0);
      chk("t2_consec1", 32'(rdcyc[1] - rdcyc[0]), 1);
      chk("t2_consec2", 32'(rdcyc[2] - rdcyc[0]), 2);
    end
    chk("t2_xfers", 32'(xcyc.size()), 3);
    if (xcyc.size() != 0 && rdcyc.size() != 0)
      chk("t2_latency", 32'(xcyc[0] - rdcyc[0]), 2);
    chk("t2_cnt1", 32'(bus.cnt1), 3);

    // Both sources loaded: bursts of four must alternate.
    clear_logs();
    for (int i = 0; i < 8; i++) begin
      fq1.push_back(8'h10 + 8'(i));
      fq2.push_back(8'h20 + 8'(i));
    end
    drain(1'b1, 200);
    chk("t3_reads", 32'(rdsrc.size()), 16);
    for (int i = 0; i < 16; i++)
      if (i < rdsrc.size()) chk($sformatf("t3_order%0d", i), 32'(rdsrc[i]), 32'((i / 4) % 2));
    chk("t3_cnt1", 32'(bus.cnt1), 11);
    chk("t3_cnt2", 32'(bus.cnt2), 8);

    // Backpressure: only two reads fit, head word holds.
    bus.m_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) fq1.push_back(8'h40 + 8'(i));
    step(12);
    chk("t4_reads_stalled", 32'(rdsrc.size()), 2);
    chk("t4_valid", 32'(bus.m_valid), 1);
    chk("t4_head", 32'(bus.m_data), 32'h40);
    step(3);
    chk("t4_reads_still", 32'(rdsrc.size()), 2);
    chk("t4_head_still", 32'(bus.m_data), 32'h40);
    bus.m_ready = 1'b1;
    drain(1'b0, 200);
    chk("t4_reads_total", 32'(rdsrc.size()), 8);
    chk("t4_cnt1", 32'(bus.cnt1), 19);

    // Source 2 disabled, then enabled.
    bus.en2 = 1'b0;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      fq1.push_back(8'h50 + 8'(i));
      fq2.push_back(8'h60 + 8'(i));
    end
    drain(1'b0, 200);
    ones = 0;
    foreach (rdsrc[i]) ones += int'(rdsrc[i]);
    chk("t5_no_rd2", 32'(ones), 0);
    chk("t5_fifo2_left", 32'(fq2.size()), 5);
    chk("t5_cnt1", 32'(bus.cnt1), 24);
    bus.en2 = 1'b1;
    drain(1'b1, 200);
    chk("t5_fifo2_empty", 32'(fq2.size()), 0);
    chk("t5_cnt2", 32'(bus.cnt2), 13);

    // Reset mid-burst with two words buffered.
    bus.m_ready = 1'b0;
    clear_logs();
    for (int i = 0; i < 8; i++) fq1.push_back(8'h70 + 8'(i));
    step(8);
    chk("t6_valid_pre", 32'(bus.m_valid), 1);
    chk("t6_reads_pre", 32'(rdsrc.size()), 2);
    rst_n = 1'b0;
    #1;
    chk("t6_valid_rst", 32'(bus.m_valid), 0);
    for (int i = 0; i < 8; i++) fq2.push_back(8'h80 + 8'(i));
    step(3);
    clear_logs();
    rst_n = 1'b1;
    bus.m_ready = 1'b1;
    drain(1'b1, 300);
    chk("t6_reads", 32'(rdsrc.size()), 14);
    if (rdsrc.size() != 0) chk("t6_first_src", 32'(rdsrc[0]), 0);
    chk("t6_cnt1", 32'(bus.cnt1), 6);
    chk("t6_cnt2", 32'(bus.cnt2), 8);

    // Randomised traffic, enables and backpressure.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(3) == 0) begin fq1.push_back(8'($urandom)); r1++; end
      if ($urandom_range(3) == 0) begin fq2.push_back(8'($urandom)); r2++; end
      bus.en1     = ($urandom_range(7) != 0);
      bus.en2     = ($urandom_range(7) != 0);
      bus.m_ready = ($urandom_range(2) != 0);
      step(1);
    end
    bus.en1 = 1'b1; bus.en2 = 1'b1; bus.m_ready = 1'b1;
    drain(1'b1, 3000);
    chk("rand_cnt1", 32'(bus.cnt1), 32'(16'(6 + r1)));
    chk("rand_cnt2", 32'(bus.cnt2), 32'(16'(8 + r2)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
